// File: rtl/iter_divider_pkg.sv
// rtl/iter_divider_pkg.sv - shared op and state encodings for the iterative divider
//
// Purpose : encodings shared between iter_divider and the execute-stage decoder.
// Contents: op codes (OP_DIV, OP_DIVU, OP_REM, OP_REMU), FSM state codes
//           (ST_IDLE, ST_CALC, ST_DONE), the XLEN / iteration-count constants
//           and an op decode helper.

package iter_divider_pkg;

    localparam int unsigned XLEN    = 64;
    localparam int unsigned K_WORD  = 32;

    // Operation encodings on the op port.
    localparam logic [1:0] OP_DIV  = 2'd0;
    localparam logic [1:0] OP_DIVU = 2'd1;
    localparam logic [1:0] OP_REM  = 2'd2;
    localparam logic [1:0] OP_REMU = 2'd3;

    // FSM state encodings.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef struct packed {
        logic is_signed;
        logic is_rem;
    } op_info_t;

    function automatic op_info_t op_decode(input logic [1:0] op);
        op_info_t info;
        case (op)
            OP_DIV:  info = '{is_signed: 1'b1, is_rem: 1'b0};
            OP_DIVU: info = '{is_signed: 1'b0, is_rem: 1'b0};
            OP_REM:  info = '{is_signed: 1'b1, is_rem: 1'b1};
            OP_REMU: info = '{is_signed: 1'b0, is_rem: 1'b1};
            default: info = '{is_signed: 1'b0, is_rem: 1'b0};
        endcase
        return info;
    endfunction

endpackage

// File: rtl/iter_divider_div_step.sv
// rtl/iter_divider_div_step.sv - one combinational restoring division iteration
//
// Purpose : shifts {rem, quo} left by one, trial-subtracts the divisor from the
//           widened partial remainder and records the quotient bit.
// Ports   : rem_i     partial remainder in (always < divisor_i)
//           quo_i     dividend/quotient shift register in
//           divisor_i unsigned divisor magnitude
//           rem_o     partial remainder out
//           quo_o     shift register out, new quotient bit in bit 0

import iter_divider_pkg::*;

module div_step #(
    parameter int W = XLEN
) (
    input  logic [W-1:0] rem_i,
    input  logic [W-1:0] quo_i,
    input  logic [W-1:0] divisor_i,
    output logic [W-1:0] rem_o,
    output logic [W-1:0] quo_o
);

    // The shifted remainder can reach 2*divisor-1, so it needs one extra bit.
    logic [W:0]   shifted;
    logic         fits;
    logic [W-1:0] diff;

    assign shifted = {rem_i, quo_i[W-1]};
    assign fits    = (shifted >= {1'b0, divisor_i});
    // When the subtraction succeeds the true difference is below the divisor,
    // so the low W bits of a modular subtract are exact.
    assign diff    = shifted[W-1:0] - divisor_i;

    assign rem_o = fits ? diff : shifted[W-1:0];
    assign quo_o = {quo_i[W-2:0], fits};

endmodule

// File: rtl/iter_divider.sv
// rtl/iter_divider.sv - multi-cycle radix-2 restoring divider for RV64M div/rem
//
// Purpose : executes div, divu, rem, remu and their W variants over K cycles
//           (K = 64, or 32 for W ops), with divide-by-zero and signed overflow
//           resolved in a single cycle.
// Ports   : clk, rst_n         clock, asynchronous active-low reset
//           in_valid/in_ready  request handshake (in_ready high only in IDLE)
//           op, word, a, b     operation, W-variant select, dividend, divisor
//           flush              abandon any in-flight operation
//           out_valid/out_ready result handshake
//           res                quotient or remainder (W results sign-extended)

import iter_divider_pkg::*;

module iter_divider #(
    parameter int N = XLEN
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [1:0]   op,
    input  logic         word,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         flush,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] res
);

    localparam int           CW      = $clog2(N + 1);
    localparam logic [N-1:0] MIN_NEG = {1'b1, {(N-1){1'b0}}};

    logic [1:0]    state_q,   state_d;
    logic [CW-1:0] cnt_q,     cnt_d;
    logic          is_rem_q,  is_rem_d;
    logic          word_q,    word_d;
    logic          sign_a_q,  sign_a_d;
    logic          sign_b_q,  sign_b_d;
    logic [N-1:0]  divisor_q, divisor_d;
    logic [N-1:0]  rem_q,     rem_d;
    logic [N-1:0]  quo_q,     quo_d;
    logic [N-1:0]  res_q,     res_d;

    // ------------------------------------------------------------------
    // Request decode (only meaningful while IDLE)
    // ------------------------------------------------------------------
    op_info_t     info;
    logic         sign_a, sign_b;
    logic [N-1:0] a_sext_w, b_sext_w;
    logic [N-1:0] a_ext, b_ext;
    logic [N-1:0] a_abs, b_abs;
    logic [N-1:0] dividend;
    logic         div_zero, overflow;

    assign info     = op_decode(op);
    assign a_sext_w = {{(N-32){a[31]}}, a[31:0]};
    assign b_sext_w = {{(N-32){b[31]}}, b[31:0]};

    always_comb begin
        sign_a = 1'b0;
        sign_b = 1'b0;
        a_ext  = a;
        b_ext  = b;
        if (word) begin
            sign_a = info.is_signed & a[31];
            sign_b = info.is_signed & b[31];
            a_ext  = info.is_signed ? a_sext_w : {{(N-32){1'b0}}, a[31:0]};
            b_ext  = info.is_signed ? b_sext_w : {{(N-32){1'b0}}, b[31:0]};
        end else begin
            sign_a = info.is_signed & a[N-1];
            sign_b = info.is_signed & b[N-1];
        end
    end

    // The most-negative value negates to itself, which is still the correct
    // unsigned magnitude.
    assign a_abs    = sign_a ? -a_ext : a_ext;
    assign b_abs    = sign_b ? -b_ext : b_ext;
    assign dividend = word ? a_sext_w : a;

    assign div_zero = word ? (b[31:0] == 32'd0) : (b == '0);
    assign overflow = info.is_signed &
                      (word ? ((a[31:0] == 32'h8000_0000) && (b[31:0] == 32'hFFFF_FFFF))
                            : ((a == MIN_NEG) && (b == '1)));

    // ------------------------------------------------------------------
    // Iteration datapath
    // ------------------------------------------------------------------
    logic [N-1:0] step_rem, step_quo;

    div_step #(
        .W (N)
    ) u_step (
        .rem_i     (rem_q),
        .quo_i     (quo_q),
        .divisor_i (divisor_q),
        .rem_o     (step_rem),
        .quo_o     (step_quo)
    );

    // Sign fix applied to the final step's output so the corrected result is
    // registered on the CALC->DONE edge.
    logic [N-1:0] quo_fix, rem_fix, sel, fixed;

    always_comb begin
        quo_fix = (sign_a_q ^ sign_b_q) ? -step_quo : step_quo;
        rem_fix = sign_a_q ? -step_rem : step_rem;
        sel     = is_rem_q ? rem_fix : quo_fix;
        fixed   = word_q ? {{(N-32){sel[31]}}, sel[31:0]} : sel;
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_rem_d  = is_rem_q;
        word_d    = word_q;
        sign_a_d  = sign_a_q;
        sign_b_d  = sign_b_q;
        divisor_d = divisor_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        res_d     = res_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    is_rem_d  = info.is_rem;
                    word_d    = word;
                    sign_a_d  = sign_a;
                    sign_b_d  = sign_b;
                    divisor_d = b_abs;
                    rem_d     = '0;
                    // W operands sit in the top half so that 32 shifts walk
                    // every dividend bit through the partial remainder.
                    quo_d     = word ? (a_abs << (N - 32)) : a_abs;
                    cnt_d     = word ? CW'(K_WORD) : CW'(N);
                    if (div_zero) begin
                        res_d   = info.is_rem ? dividend : '1;
                        state_d = ST_DONE;
                    end else if (overflow) begin
                        res_d   = info.is_rem ? '0 : dividend;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                rem_d = step_rem;
                quo_d = step_quo;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    res_d   = fixed;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A pipeline kill overrides everything, including a same-cycle
        // request or result handoff.
        if (flush) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            is_rem_q  <= 1'b0;
            word_q    <= 1'b0;
            sign_a_q  <= 1'b0;
            sign_b_q  <= 1'b0;
            divisor_q <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            res_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_rem_q  <= is_rem_d;
            word_q    <= word_d;
            sign_a_q  <= sign_a_d;
            sign_b_q  <= sign_b_d;
            divisor_q <= divisor_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            res_q     <= res_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign res       = res_q;

endmodule

// File: tb/tb_iter_divider.sv
// tb/tb_iter_divider.sv - scoreboard testbench for iter_divider

import iter_divider_pkg::*;

module tb_iter_divider;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  op;
    logic        word;
    logic [63:0] a;
    logic [63:0] b;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] res;

    iter_divider #(.N(64)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .word      (word),
        .a         (a),
        .b         (b),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res       (res)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] res;
        int          acc;
        int          lat;
    } exp_t;

    exp_t exp_q[$];
    int   checks;
    int   failures;
    int   cyc;
    logic mon_seen;

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=0x%016h expected=0x%016h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    // Reference: RISC-V M semantics computed with native signed/unsigned arithmetic.
    function automatic logic [63:0] model(input logic [1:0] o, input logic w,
                                          input logic [63:0] x, input logic [63:0] y,
                                          output int lat);
        longint          sx, sy, sq, sr;
        longint unsigned ux, uy, uq, ur;
        int              xi, yi;
        logic            sgn, want_rem, special;
        logic [63:0]     q, r, sel;
        sgn      = (o == OP_DIV) || (o == OP_REM);
        want_rem = (o == OP_REM) || (o == OP_REMU);
        special  = 1'b0;
        if (sgn) begin
            if (w) begin
                xi = x[31:0];
                yi = y[31:0];
                sx = xi;
                sy = yi;
            end else begin
                sx = x;
                sy = y;
            end
            if (sy == 0) begin
                sq = -1; sr = sx; special = 1'b1;
            end else if (sy == -1 && ((w && sx == -64'sd2147483648) ||
                                      (!w && sx == 64'sh8000_0000_0000_0000))) begin
                sq = sx; sr = 0; special = 1'b1;
            end else begin
                sq = sx / sy; sr = sx % sy;
            end
            q = sq;
            r = sr;
        end else begin
            ux = w ? {32'd0, x[31:0]} : x;
            uy = w ? {32'd0, y[31:0]} : y;
            if (uy == 0) begin
                uq = '1; ur = ux; special = 1'b1;
            end else begin
                uq = ux / uy; ur = ux % uy;
            end
            q = uq;
            r = ur;
        end
        sel = want_rem ? r : q;
        if (w) sel = {{32{sel[31]}}, sel[31:0]};
        lat = special ? 1 : (w ? 33 : 65);
        return sel;
    endfunction

    // Monitor: compares every presented result against the head of the scoreboard.
    initial begin
        exp_t e;
        mon_seen = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_out_valid", {63'd0, out_valid}, 64'd0);
                end else begin
                    e = exp_q[0];
                    if (!mon_seen) chk("latency", 64'(cyc - e.acc), 64'(e.lat));
                    chk("res", res, e.res);
                    chk("in_ready_while_done", {63'd0, in_ready}, 64'd0);
                    if (out_ready && !flush) void'(exp_q.pop_front());
                end
            end
            mon_seen = rst_n && out_valid;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [1:0] o, input logic w,
                           input logic [63:0] x, input logic [63:0] y);
        exp_t e;
        chk("in_ready_before_issue", {63'd0, in_ready}, 64'd1);
        e.res = model(o, w, x, y, e.lat);
        e.acc = cyc;
        op = o; word = w; a = x; b = y; in_valid = 1'b1;
        exp_q.push_back(e);
        tick();
        // Scramble the request inputs: they must be ignored after accept.
        in_valid = 1'b0;
        op   = 2'($urandom_range(0, 3));
        word = 1'($urandom_range(0, 1));
        a    = {$urandom, $urandom};
        b    = 64'd0;
    endtask

    task automatic do_op(input logic [1:0] o, input logic w,
                         input logic [63:0] x, input logic [63:0] y, input int hold);
        int t;
        present(o, w, x, y);
        t = 0;
        while (!out_valid && t < 200) begin
            tick();
            t++;
        end
        if (!out_valid) begin
            chk("result_timeout", {63'd0, out_valid}, 64'd1);
            exp_q.delete();
            return;
        end
        repeat (hold) tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("out_valid_after_take", {63'd0, out_valid}, 64'd0);
        chk("in_ready_after_take", {63'd0, in_ready}, 64'd1);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        logic [63:0] x, y;
        int          mode;
        rst_n = 1'b0; in_valid = 1'b0; op = OP_DIV; word = 1'b0;
        a = '0; b = '0; flush = 1'b0; out_ready = 1'b0;
        checks = 0; failures = 0;
        #1;
        chk("reset_in_ready", {63'd0, in_ready}, 64'd1);
        chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
        chk("reset_res", res, 64'd0);
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        do_op(OP_DIV,  1'b0, 64'd100, -64'sd7, 0);
        do_op(OP_REM,  1'b0, 64'd100, -64'sd7, 0);
        do_op(OP_DIVU, 1'b0, '1, 64'd0, 0);
        do_op(OP_REMU, 1'b0, '1, 64'd0, 0);
        do_op(OP_DIV,  1'b0, 64'h8000_0000_0000_0000, '1, 0);
        do_op(OP_REM,  1'b0, 64'h8000_0000_0000_0000, '1, 0);
        do_op(OP_DIVU, 1'b1, 64'h0000_0000_FFFF_FFFE, 64'd2, 0);
        do_op(OP_REMW_SAFE(), 1'b1, -64'sd7, 64'd2, 0);
        do_op(OP_DIV,  1'b1, 64'h1234_5678_8000_0000, 64'hABCD_0000_FFFF_FFFF, 0);
        do_op(OP_DIVU, 1'b1, 64'd5, 64'hFFFF_FFFF_0000_0000, 1);
        do_op(OP_DIV,  1'b0, 64'd123456789, 64'd1000, 10);

        // Request presented together with flush is dropped.
        op = OP_DIVU; word = 1'b0; a = 64'd9; b = 64'd3; in_valid = 1'b1; flush = 1'b1;
        tick();
        in_valid = 1'b0; flush = 1'b0;
        chk("flush_drops_request", {63'd0, in_ready}, 64'd1);
        repeat (70) tick();

        // Flush around iteration 20.
        present(OP_DIVU, 1'b0, 64'hFEDC_BA98_7654_3210, 64'd12345);
        repeat (19) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_calc_in_ready", {63'd0, in_ready}, 64'd1);
        chk("flush_calc_out_valid", {63'd0, out_valid}, 64'd0);
        exp_q.delete();
        repeat (70) tick();

        // Flush in DONE wins over a simultaneous out_ready.
        present(OP_REMU, 1'b0, 64'd77, 64'd0);
        chk("special_done", {63'd0, out_valid}, 64'd1);
        out_ready = 1'b1; flush = 1'b1;
        tick();
        out_ready = 1'b0; flush = 1'b0;
        chk("flush_done_in_ready", {63'd0, in_ready}, 64'd1);
        chk("flush_done_out_valid", {63'd0, out_valid}, 64'd0);
        exp_q.delete();

        // Asynchronous reset during CALC.
        present(OP_DIV, 1'b0, -64'sd1000000, 64'd17);
        repeat (10) tick();
        rst_n = 1'b0;
        #1;
        chk("async_reset_in_ready", {63'd0, in_ready}, 64'd1);
        chk("async_reset_out_valid", {63'd0, out_valid}, 64'd0);
        chk("async_reset_res", res, 64'd0);
        exp_q.delete();
        tick();
        rst_n = 1'b1;
        repeat (70) tick();
        do_op(OP_DIVU, 1'b0, 64'd10, 64'd3, 0);

        for (int i = 0; i < 40; i++) begin
            mode = $urandom_range(0, 5);
            x = {$urandom, $urandom};
            y = {$urandom, $urandom};
            case (mode)
                0: y = 64'd0;
                1: y = 64'($urandom_range(1, 20));
                2: y = -64'($urandom_range(1, 20));
                3: begin x = 64'h8000_0000_0000_0000; y = '1; end
                4: begin x = {32'd0, 32'h8000_0000}; y = {32'd0, 32'hFFFF_FFFF}; end
                default: ;
            endcase
            do_op(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), x, y,
                  $urandom_range(0, 3));
        end

        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    function automatic logic [1:0] OP_REMW_SAFE();
        return OP_REM;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

endmodule
